// File: rtl/seg7_count_monitor.sv
// Receive-side monitor for a two-digit active-low 7-segment count display:
// debounces the segment pair, decodes it to 0..99 and classifies each accepted change.
module seg7_count_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_VAL       = 31,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       disp1_in,
  input  logic [6:0]       disp0_in,
  output logic [6:0]       value,
  output logic             value_valid,
  output logic             update,
  output logic             step_up,
  output logic             step_down,
  output logic             wrap_up,
  output logic             reload,
  output logic             jump,
  output logic             blank,
  output logic             glyph_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int             CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]     DASH    = 7'b0111111;

  typedef enum logic [1:0] {S_EMPTY, S_ARMED, S_VALID} state_t;

  state_t           state_q, state_d;
  logic [13:0]      cand_q, cand_d;
  logic [13:0]      acc_q, acc_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic [6:0]       value_q, value_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic update_q, update_d, up_q, up_d, dn_q, dn_d, wrap_q, wrap_d;
  logic reload_q, reload_d, jump_q, jump_d, blank_q, blank_d, gerr_q, gerr_d;

  logic [13:0] pair;
  logic        accept;
  logic [4:0]  dec1, dec0;
  logic [6:0]  newv;

  // {legal, digit}; dash and all unknown patterns report illegal
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = {1'b1, 4'd0};
      7'b1111001: decode = {1'b1, 4'd1};
      7'b0100100: decode = {1'b1, 4'd2};
      7'b0110000: decode = {1'b1, 4'd3};
      7'b0011001: decode = {1'b1, 4'd4};
      7'b0010010: decode = {1'b1, 4'd5};
      7'b0000010: decode = {1'b1, 4'd6};
      7'b1111000: decode = {1'b1, 4'd7};
      7'b0000000: decode = {1'b1, 4'd8};
      7'b0011000: decode = {1'b1, 4'd9};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  assign pair = {disp1_in, disp0_in};
  assign dec1 = decode(cand_q[13:7]);
  assign dec0 = decode(cand_q[6:0]);
  assign newv = ({3'b000, dec1[3:0]} * 7'd10) + {3'b000, dec0[3:0]};

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    acc_d    = acc_q;
    stab_d   = stab_q;
    value_d  = value_q;
    err_d    = err_q;
    update_d = 1'b0;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    wrap_d   = 1'b0;
    reload_d = 1'b0;
    jump_d   = 1'b0;
    blank_d  = 1'b0;
    gerr_d   = 1'b0;
    accept   = 1'b0;

    if (pair != cand_q) begin
      cand_d = pair;
      stab_d = '0;
    end else if (stab_q < CNT_MAX) begin
      stab_d = stab_q + 1'b1;
    end else if (state_q == S_EMPTY || cand_q != acc_q) begin
      accept = 1'b1;
    end

    if (accept) begin
      acc_d    = cand_q;
      update_d = 1'b1;
      if (dec1[4] && dec0[4]) begin
        value_d = newv;
        state_d = S_VALID;
        // only a valid->valid change is a step; distinct patterns imply distinct values
        if (state_q == S_VALID) begin
          if (value_q == 7'(MAX_VAL) && newv == 7'd0)            wrap_d   = 1'b1;
          else if (value_q == 7'd0 && newv > 7'd1)               reload_d = 1'b1;
          else if (newv == value_q + 7'd1)                       up_d     = 1'b1;
          else if (value_q != 7'd0 && newv == value_q - 7'd1)    dn_d     = 1'b1;
          else                                                   jump_d   = 1'b1;
        end
      end else if (cand_q[13:7] == DASH && cand_q[6:0] == DASH) begin
        blank_d = 1'b1;
        state_d = S_ARMED;
      end else begin
        gerr_d  = 1'b1;
        if (!(&err_q)) err_d = err_q + 1'b1;
        state_d = S_ARMED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_EMPTY;
      cand_q   <= '0;
      acc_q    <= '0;
      stab_q   <= '0;
      value_q  <= '0;
      err_q    <= '0;
      update_q <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      wrap_q   <= 1'b0;
      reload_q <= 1'b0;
      jump_q   <= 1'b0;
      blank_q  <= 1'b0;
      gerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      acc_q    <= acc_d;
      stab_q   <= stab_d;
      value_q  <= value_d;
      err_q    <= err_d;
      update_q <= update_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      wrap_q   <= wrap_d;
      reload_q <= reload_d;
      jump_q   <= jump_d;
      blank_q  <= blank_d;
      gerr_q   <= gerr_d;
    end
  end

  assign value       = value_q;
  assign value_valid = (state_q == S_VALID);
  assign update      = update_q;
  assign step_up     = up_q;
  assign step_down   = dn_q;
  assign wrap_up     = wrap_q;
  assign reload      = reload_q;
  assign jump        = jump_q;
  assign blank       = blank_q;
  assign glyph_err   = gerr_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Directed bench for seg7_count_monitor: filter latency, step classes, glitches,
// glyph errors with saturation, blanking and mid-filter reset.
module tb_seg7_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] d1, d0;
  logic [6:0] value;
  logic       value_valid, update, step_up, step_down, wrap_up, reload, jump, blank, glyph_err;
  logic [7:0] err_count;
  logic [7:0] pv;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] P_UPD = 8'h80, P_UP = 8'h40, P_DN = 8'h20, P_WRAP = 8'h10,
                         P_REL = 8'h08, P_JMP = 8'h04, P_BLK = 8'h02, P_ERR = 8'h01;
  localparam logic [6:0] DASH = 7'b0111111, BAD = 7'b0000111, ALL1 = 7'b1111111;
  localparam logic [6:0] G [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                    7'b0000000, 7'b0011000};

  seg7_count_monitor dut (
    .clk(clk), .rst(rst), .disp1_in(d1), .disp0_in(d0),
    .value(value), .value_valid(value_valid), .update(update),
    .step_up(step_up), .step_down(step_down), .wrap_up(wrap_up), .reload(reload),
    .jump(jump), .blank(blank), .glyph_err(glyph_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  assign pv = {update, step_up, step_down, wrap_up, reload, jump, blank, glyph_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive a pattern, require silence for 4 edges, then stop just after the accepting edge
  task automatic show(input string tag, input logic [6:0] a, input logic [6:0] b);
    d1 = a; d0 = b;
    repeat (4) @(posedge clk);
    #1 chk({tag, "_quiet"}, pv, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] a, input logic [6:0] b);
    d1 = a; d0 = b;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seen;
    rst = 1'b0; d1 = 7'h55; d0 = 7'h2A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", value, 0);
    chk("rst_vv", value_valid, 0);
    chk("rst_pulses", pv, 0);
    chk("rst_err", err_count, 0);

    d1 = ALL1; d0 = ALL1; rst = 1'b1;
    show("t1", ALL1, ALL1);
    chk("t1_pulses", pv, P_UPD | P_ERR);
    chk("t1_err", err_count, 1);
    chk("t1_vv", value_valid, 0);

    show("t2a", G[0], G[1]);
    chk("t2a_pulses", pv, P_UPD);
    chk("t2a_value", value, 1);
    chk("t2a_vv", value_valid, 1);
    show("t2b", G[0], G[2]);
    chk("t2b_pulses", pv, P_UPD | P_UP);
    chk("t2b_value", value, 2);

    show("t3a", G[3], G[1]);
    chk("t3a_pulses", pv, P_UPD | P_JMP);
    chk("t3a_value", value, 31);
    show("t3b", G[0], G[0]);
    chk("t3b_pulses", pv, P_UPD | P_WRAP);
    chk("t3b_value", value, 0);
    show("t3c", G[1], G[7]);
    chk("t3c_pulses", pv, P_UPD | P_REL);
    chk("t3c_value", value, 17);
    show("t3d", G[0], G[5]);
    chk("t3d_pulses", pv, P_UPD | P_JMP);
    show("t3e", G[0], G[4]);
    chk("t3e_pulses", pv, P_UPD | P_DN);
    chk("t3e_value", value, 4);
    show("t3f", G[0], G[9]);
    chk("t3f_pulses", pv, P_UPD | P_JMP);
    chk("t3f_value", value, 9);
    show("t3g", G[0], G[5]);
    chk("t3g_pulses", pv, P_UPD | P_JMP);

    // short glitch on the ones digit must vanish entirely
    seen = '0;
    d0 = G[6];
    repeat (3) begin @(posedge clk); #1 seen |= pv; end
    d0 = G[5];
    repeat (10) begin @(posedge clk); #1 seen |= pv; end
    chk("t4_quiet", seen, 0);
    chk("t4_value", value, 5);
    chk("t4_vv", value_valid, 1);

    show("t5", G[0], BAD);
    chk("t5_pulses", pv, P_UPD | P_ERR);
    chk("t5_vv", value_valid, 0);
    chk("t5_value", value, 5);
    chk("t5_err", err_count, 2);
    for (int i = 0; i < 300; i++) hold(G[0], (i % 2 == 0) ? ALL1 : BAD);
    chk("t5_sat", err_count, 255);

    show("t6a", DASH, DASH);
    chk("t6a_pulses", pv, P_UPD | P_BLK);
    chk("t6a_vv", value_valid, 0);
    chk("t6a_value", value, 5);
    show("t6b", G[0], G[7]);
    chk("t6b_pulses", pv, P_UPD);
    chk("t6b_value", value, 7);
    chk("t6b_vv", value_valid, 1);

    // reset partway through the filter of "08"
    d1 = G[0]; d0 = G[8];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t7_rst_value", value, 0);
    chk("t7_rst_err", err_count, 0);
    chk("t7_rst_vv", value_valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    show("t7a", G[0], G[8]);
    chk("t7a_pulses", pv, P_UPD);
    chk("t7a_value", value, 8);
    show("t7b", G[0], G[9]);
    chk("t7b_pulses", pv, P_UPD | P_UP);
    chk("t7b_value", value, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
